// File: rtl/pulse_stretch_if.sv
// Event input and stretched-output bundle for pulse_stretch.
// The slave modport is the stretcher side; master is the event source / observer.
interface pulse_stretch_if #(
    parameter int unsigned PEND_W = 2
);
    logic              sig_in;
    logic              sig_out;
    logic              busy;
    logic [PEND_W-1:0] pend_cnt;
    logic              overflow;

    modport master (
        output sig_in,
        input  sig_out,
        input  busy,
        input  pend_cnt,
        input  overflow
    );

    modport slave (
        input  sig_in,
        output sig_out,
        output busy,
        output pend_cnt,
        output overflow
    );
endinterface

// File: rtl/pulse_stretch.sv
// Stretches each sampled event into a HOLD_CYCLES-high window followed by at least
// GAP_CYCLES low cycles; events arriving while busy are queued in a saturating counter.
module pulse_stretch #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned PEND_W      = 2
) (
    input logic           clk,
    input logic           rst_n,
    pulse_stretch_if.slave bus
);
    localparam int unsigned CNT_MAX =
        ((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) - 1;
    localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_INIT  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              sig_out_q, busy_q, ovf_q, ovf_d;
    logic              inc, dec;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inc     = 1'b0;
        dec     = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.sig_in) begin
                    state_d = StHold;
                    cnt_d   = HOLD_INIT;
                end
            end
            StHold: begin
                inc = bus.sig_in;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = StGap;
                    cnt_d   = GAP_INIT;
                end
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    inc   = bus.sig_in;
                end else if (pend_q != '0) begin
                    // Serve the oldest queued event; a new one arriving now takes its slot.
                    state_d = StHold;
                    cnt_d   = HOLD_INIT;
                    dec     = 1'b1;
                    inc     = bus.sig_in;
                end else if (bus.sig_in) begin
                    state_d = StHold;
                    cnt_d   = HOLD_INIT;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        ovf_d  = 1'b0;
        if (inc && !dec) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pend_q    <= '0;
            sig_out_q <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            sig_out_q <= (state_d == StHold);
            busy_q    <= (state_d != StIdle);
            ovf_q     <= ovf_d;
        end
    end

    assign bus.sig_out  = sig_out_q;
    assign bus.busy     = busy_q;
    assign bus.pend_cnt = pend_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_pulse_stretch.sv
// Directed scenarios plus random event traffic, compared every cycle against a
// window-schedule model (window start edge, queued count) of the stretcher.
module tb_pulse_stretch;
    localparam int unsigned H      = 4;
    localparam int unsigned G      = 2;
    localparam int unsigned PEND_W = 2;
    localparam int          PMAX   = (1 << PEND_W) - 1;

    logic clk;
    logic rst_n;

    pulse_stretch_if #(.PEND_W(PEND_W)) bus ();

    pulse_stretch #(
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G),
        .PEND_W     (PEND_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a window occupies edges [start, start+H+G); the edge start+H+G decides what follows.
    bit m_active;
    int m_start;
    int m_pend;
    bit m_ovf;
    int edge_no;

    int rises;
    int ovf_seen;
    bit prev_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_start  = 0;
        m_pend   = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_step(input bit s);
        m_ovf = 1'b0;
        if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                m_start  = edge_no;
            end
        end else if (edge_no == m_start + int'(H + G)) begin
            if (m_pend > 0) begin
                m_start = edge_no;
                if (!s) m_pend--;
            end else if (s) begin
                m_start = edge_no;
            end else begin
                m_active = 1'b0;
            end
        end else if (s) begin
            if (m_pend == PMAX) m_ovf = 1'b1;
            else m_pend++;
        end
    endtask

    task automatic check_outputs();
        logic exp_out;
        exp_out = m_active && ((edge_no - m_start) < int'(H));
        check("sig_out",  32'(bus.sig_out),  32'(exp_out));
        check("busy",     32'(bus.busy),     32'(m_active));
        check("pend_cnt", 32'(bus.pend_cnt), 32'(m_pend));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic tick(input bit s);
        bus.sig_in = s;
        @(posedge clk);
        edge_no++;
        if (rst_n) model_step(s);
        else model_reset();
        #1;
        check_outputs();
        if (bus.sig_out && !prev_out) rises++;
        if (bus.overflow) ovf_seen++;
        prev_out = bus.sig_out;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    // Assert reset between edges, check the immediate clear, optionally hold it across edges.
    task automatic reset_pulse(input int edges);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_sig_out",  32'(bus.sig_out),  32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_pend_cnt", 32'(bus.pend_cnt), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < edges; i++) tick(1'($urandom_range(0, 1)));
        #1;
        rst_n = 1'b1;
        prev_out = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.sig_in = 1'b0;
        edge_no    = 0;
        rises      = 0;
        ovf_seen   = 0;
        prev_out   = 1'b0;
        model_reset();
        #1;
        check_outputs();
        tick(1'b1);
        tick(1'b1);
        #3;
        rst_n = 1'b1;

        // Single event.
        idle(3);
        tick(1'b1);
        idle(10);

        // Queued event two edges after the first.
        tick(1'b1); tick(1'b0); tick(1'b1);
        idle(14);

        // Five-cycle burst: three queued, one dropped, four windows in total.
        rises    = 0;
        ovf_seen = 0;
        for (int i = 0; i < 5; i++) tick(1'b1);
        idle(30);
        check("burst_windows",  32'(rises),    32'd4);
        check("burst_overflow", 32'(ovf_seen), 32'd1);

        // New event exactly at the end of the gap.
        tick(1'b1);
        idle(5);
        tick(1'b1);
        idle(12);

        // Queued event plus a fresh one at the final gap cycle.
        tick(1'b1); tick(1'b0); tick(1'b1);
        idle(3);
        tick(1'b1);
        idle(20);

        // Reset mid-HOLD with two events queued, then one event afterwards.
        tick(1'b1); tick(1'b1); tick(1'b1);
        reset_pulse(0);
        idle(2);
        tick(1'b1);
        idle(10);

        // Random traffic with occasional resets, some held across edges.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) reset_pulse(int'($urandom_range(0, 2)));
            else tick(1'($urandom_range(0, 99) < 45));
        end
        idle(40);
        check("final_busy", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
